alu_issue_controller: RTL

Single-issue sequencer that drives the tensor core's 8-bit ALU from the instruction side.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8×8-bit signed register file.
- Presents opcode and operands to the ALU for one cycle, waits the ALU's registered latency, then writes the result back.
- Also resolves load-immediate instructions locally and flags illegal opcodes.

---
 rtl/alu_issue_pkg.sv | 40 ++++
 rtl/alu_issue_regfile.sv | 35 +++
 rtl/alu_issue_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// Opcodes, FSM states and instruction field positions.
package alu_issue_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int OPC_W      = 3;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  localparam logic [OPC_W-1:0] OP_ADD      = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB      = 3'b001;
  localparam logic [OPC_W-1:0] OP_MUL      = 3'b010;
  localparam logic [OPC_W-1:0] OP_EQ       = 3'b011;
  localparam logic [OPC_W-1:0] OP_GT       = 3'b100;
  localparam logic [OPC_W-1:0] OP_LOAD_IMM = 3'b101;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } issue_state_t;

  function automatic logic is_alu_op(
    input logic [OPC_W-1:0] op
  );
    return op <= OP_GT;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x8 register file: one synchronous write port,
// three combinational read ports (rs1, rs2, debug).
import alu_issue_pkg::*;

module alu_issue_regfile (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  input  logic [REG_ADDR_W-1:0] raddr3,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2,
  output logic [DATA_W-1:0]     rdata3
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
  assign rdata3 = mem_q[raddr3];

endmodule

// File: rtl/alu_issue_controller.sv
// Single-issue sequencer feeding an 8-bit ALU with a
// fixed registered latency; LOAD_IMM resolved locally.
import alu_issue_pkg::*;

module alu_issue_controller #(
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  instr_valid_in,
  input  logic [15:0]           instr_in,
  output logic                  instr_ready_out,
  output logic                  alu_reset_out,
  output logic                  alu_enable_out,
  output logic [OPC_W-1:0]      alu_opcode_out,
  output logic [DATA_W-1:0]     alu_operand1_out,
  output logic [DATA_W-1:0]     alu_operand2_out,
  input  logic [DATA_W-1:0]     alu_result_in,
  output logic                  result_valid_out,
  output logic [REG_ADDR_W-1:0] result_rd_out,
  output logic [DATA_W-1:0]     result_data_out,
  output logic                  illegal_out,
  output logic                  busy_out,
  input  logic [REG_ADDR_W-1:0] reg_read_addr_in,
  output logic [DATA_W-1:0]     reg_read_data_out
);

  localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

  issue_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic ready_q, ready_d;
  logic alu_rst_q;
  logic res_valid_q, res_valid_d;
  logic [REG_ADDR_W-1:0] res_rd_q, res_rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic illegal_q, illegal_d;

  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rs1_data;
  logic [DATA_W-1:0]     rs2_data;

  logic [OPC_W-1:0]      in_opc;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic [REG_ADDR_W-1:0] in_rs2;
  logic [DATA_W-1:0]     in_imm;
  logic                  accept;
  logic                  issuing;

  assign in_opc = instr_in[OPC_MSB:OPC_LSB];
  assign in_rd  = instr_in[RD_MSB:RD_LSB];
  assign in_rs1 = instr_in[RS1_MSB:RS1_LSB];
  assign in_rs2 = instr_in[RS2_MSB:RS2_LSB];
  assign in_imm = instr_in[IMM_MSB:IMM_LSB];
  assign accept = instr_valid_in && ready_q;

  alu_issue_regfile u_regfile (
    .clk    (clock_in),
    .rst_n  (reset_n_in),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (rs1_q),
    .raddr2 (rs2_q),
    .raddr3 (reg_read_addr_in),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .rdata3 (reg_read_data_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opc_d       = opc_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    res_valid_d = 1'b0;
    res_rd_d    = res_rd_q;
    res_data_d  = res_data_q;
    illegal_d   = 1'b0;
    we          = 1'b0;
    waddr       = rd_q;
    wdata       = alu_result_in;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_alu_op(in_opc): begin
              opc_d   = in_opc;
              rd_d    = in_rd;
              rs1_d   = in_rs1;
              rs2_d   = in_rs2;
              state_d = ST_ISSUE;
            end
            (in_opc == OP_LOAD_IMM): begin
              we          = 1'b1;
              waddr       = in_rd;
              wdata       = in_imm;
              res_valid_d = 1'b1;
              res_rd_d    = in_rd;
              res_data_d  = in_imm;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          we          = 1'b1;
          res_valid_d = 1'b1;
          res_rd_d    = rd_q;
          res_data_d  = alu_result_in;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // ALU reset stays high through the first edge after release.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      opc_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      ready_q     <= 1'b0;
      alu_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opc_q       <= opc_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      ready_q     <= ready_d;
      alu_rst_q   <= 1'b0;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      illegal_q   <= illegal_d;
    end
  end

  assign issuing          = (state_q == ST_ISSUE);
  assign alu_enable_out   = issuing;
  assign alu_opcode_out   = issuing ? opc_q : '0;
  assign alu_operand1_out = issuing ? rs1_data : '0;
  assign alu_operand2_out = issuing ? rs2_data : '0;
  assign alu_reset_out    = alu_rst_q;
  assign instr_ready_out  = ready_q;
  assign result_valid_out = res_valid_q;
  assign result_rd_out    = res_rd_q;
  assign result_data_out  = res_data_q;
  assign illegal_out      = illegal_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule
